vga_text_writer: RTL
====================

# vga_text_writer

Console-side writer for the VGA text display. Accepts a byte stream over a valid/ready handshake, interprets printable characters and a few control codes, and converts them into single-cycle video-memory write strobes (`Memwrite`/`Addrin`/`BUS`) on the same clock as the display's memory write port. It maintains the cursor and handles line wrap, row wrap with line erase, and full-screen clear.

## Interface

Parameters:
- `COLS`, default 32: characters per row; cursor column range 0..COLS-1.
- `ROWS`, default 30: rows per screen; cursor row range 0..ROWS-1.
- `BLANK`, default 8'h20: fill code written by all clear operations.

Ports:
- `clk_50mhz`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `char_data`  input  8  byte to process.
- `char_valid`  input  1  `char_data` valid.
- `char_ready`  output  1  writer can accept a byte this cycle.
- `Memwrite`  output  2  bit 0 is the VM write strobe; bit 1 is always 0.
- `Addrin`  output  32  VM address, `row*COLS + col`, zero-extended.
- `BUS`  output  32  write data, `{24'b0, code}` while strobing; 0 otherwise.
- `cursor_row`  output  5  current cursor row.
- `cursor_col`  output  5  current cursor column.
- `busy`  output  1  high in any state other than IDLE.

## Operation

- States: IDLE, PUT, LCLR (clear one row), SCLR (clear screen).
- IDLE: `char_ready`=1. A handshake occurs when `char_valid && char_ready`. The byte is decoded:
  - 0x20..0x7E → PUT.
  - 0x0D (CR) → col=0; stay IDLE.
  - 0x0A (LF) → row advance (see below).
  - 0x08 (BS) → col-1 if col>0, otherwise no change; no write; stay IDLE.
  - 0x0C (FF) → SCLR.
  - Any other byte is consumed and ignored.
- PUT: one strobe at the current (row,col) with the byte. Then:
  - If col<COLS-1: col+1, go to IDLE.
  - Otherwise: col=0 and row advance.
- Row advance:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Enter LCLR for the new row.
  - Every new line therefore starts blank.
- LCLR: COLS strobes of `BLANK`, at addresses row*COLS+0 .. row*COLS+COLS-1 on consecutive cycles. Then IDLE. The cursor is unchanged (col is already 0 for LF-from-wrap; for LF alone, col keeps its value).
- SCLR: ROWS*COLS strobes of `BLANK`, at addresses 0 .. ROWS*COLS-1 ascending on consecutive cycles. Then row=col=0 and IDLE.
- `char_ready`=0 in PUT, LCLR and SCLR. No bytes are dropped; the source holds its byte.
- Reset values: `char_ready`=0 during reset, then 1 (IDLE). `Memwrite`=0, `Addrin`=0, `BUS`=0, cursor 0/0, `busy`=0. The exception is in Configuration.
- Reset mid-operation aborts any sweep immediately. Partially written VM contents are left as they are.

## Timing

- All outputs are registered.
- Printable byte accepted at edge N: strobe (`Memwrite`=2'b01) valid during cycle N+1. Back in IDLE with `char_ready`=1 at cycle N+2. Throughput is one printable byte per 2 cycles.
- CR/BS/ignored bytes: cursor updates at N+1, `char_ready` stays 1, so one byte per cycle.
- LF: LCLR strobes during N+1..N+COLS, `char_ready` returns at N+COLS+1.
- Wrap from PUT: PUT strobe at N+1, LCLR strobes N+2..N+COLS+1.
- FF: strobes N+1..N+ROWS*COLS.
- `Memwrite[0]` is never high for more than one cycle per address.
- `Addrin` and `BUS` hold 0 whenever `Memwrite[0]`=0.

## Configuration

- `VGA_TEXT_CLEAR_ON_RESET_EN` defined:
  - On reset release the block enters SCLR instead of IDLE, with `busy`=1 and `char_ready`=0 for ROWS*COLS cycles.
  - The screen is filled with `BLANK`, then the block goes to IDLE with the cursor at 0/0.
- Undefined: the block goes straight to IDLE after reset and VM contents are untouched.

## Test plan

- Reset, then send 'A' (0x41): one strobe with `Addrin`=0, `BUS`=0x41; cursor 0/1; `char_ready` back 2 cycles after the handshake.
- Send 32 × 0x42 from 0/0: strobes at 0..31, then 32 BLANK strobes at 32..63; cursor ends 1/0; `char_ready` low throughout each sweep.
- Cursor at 29/5, send LF: 32 BLANK strobes at 0..31 (row wrap); cursor 0/5.
- Cursor 3/7, send CR, BS, BS: cursor 3/0 after CR, stays 3/0 after both BS; no strobes; `char_ready` held 1.
- Send FF mid-screen: 960 consecutive BLANK strobes at addresses 0..959; cursor 0/0; `busy` high for exactly 960 cycles. Assert `rst` at strobe 100: all outputs 0 immediately.
- With `VGA_TEXT_CLEAR_ON_RESET_EN`: release reset → 960 BLANK strobes before the first `char_ready`=1. Without it: `char_ready`=1 on the first cycle after release.

Source files
------------

// File: rtl/vga_text_writer.sv
// Byte-stream console writer: turns characters and control codes into VM write strobes.
// Optional VGA_TEXT_CLEAR_ON_RESET_EN: blank the whole screen after reset release.
module vga_text_writer #(
   parameter int         COLS  = 32,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic        clk_50mhz,
   input  logic        rst,
   input  logic [7:0]  char_data,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [1:0]  Memwrite,
   output logic [31:0] Addrin,
   output logic [31:0] BUS,
   output logic [4:0]  cursor_row,
   output logic [4:0]  cursor_col,
   output logic        busy
);

   localparam int CELLS = ROWS * COLS;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PUT  = 2'd1;
   localparam logic [1:0] LCLR = 2'd2;
   localparam logic [1:0] SCLR = 2'd3;

`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
   localparam logic [1:0] RST_ST = SCLR;
`else
   localparam logic [1:0] RST_ST = IDLE;
`endif

   logic [1:0]  st;
   logic [31:0] ptr;
   logic [31:0] last;
   logic [4:0]  nrow;
   logic [31:0] cur_addr;
   logic [31:0] nrow_base;
   logic        printable;

   assign nrow      = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
   assign cur_addr  = 32'(cursor_row) * 32'(COLS) + 32'(cursor_col);
   assign nrow_base = 32'(nrow) * 32'(COLS);
   assign printable = (char_data >= 8'h20) && (char_data <= 8'h7e);

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         st         <= RST_ST;
         ptr        <= 32'd0;
         last       <= 32'(CELLS - 1);
         Memwrite   <= 2'b00;
         Addrin     <= 32'd0;
         BUS        <= 32'd0;
         char_ready <= 1'b0;
         busy       <= 1'b0;
         cursor_row <= 5'd0;
         cursor_col <= 5'd0;
      end else begin
         Memwrite <= 2'b00;
         Addrin   <= 32'd0;
         BUS      <= 32'd0;
         case (st)
            IDLE: begin
               char_ready <= 1'b1;
               busy       <= 1'b0;
               if (char_valid && char_ready) begin
                  unique case (1'b1)
                     printable: begin
                        st         <= PUT;
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                        Memwrite   <= 2'b01;
                        Addrin     <= cur_addr;
                        BUS        <= {24'd0, char_data};
                     end
                     (char_data == 8'h0d): cursor_col <= 5'd0;
                     (char_data == 8'h0a): begin
                        cursor_row <= nrow;
                        st         <= LCLR;
                        ptr        <= nrow_base;
                        last       <= nrow_base + 32'(COLS - 1);
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                        Memwrite   <= 2'b01;
                        Addrin     <= nrow_base;
                        BUS        <= {24'd0, BLANK};
                     end
                     (char_data == 8'h08): begin
                        if (cursor_col != 5'd0)
                           cursor_col <= cursor_col - 5'd1;
                     end
                     (char_data == 8'h0c): begin
                        st         <= SCLR;
                        ptr        <= 32'd0;
                        last       <= 32'(CELLS - 1);
                        char_ready <= 1'b0;
                        busy       <= 1'b1;
                        Memwrite   <= 2'b01;
                        Addrin     <= 32'd0;
                        BUS        <= {24'd0, BLANK};
                     end
                     default: ;
                  endcase
               end
            end
            PUT: begin
               if (cursor_col < 5'(COLS - 1)) begin
                  cursor_col <= cursor_col + 5'd1;
                  st         <= IDLE;
                  char_ready <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  cursor_col <= 5'd0;
                  cursor_row <= nrow;
                  st         <= LCLR;
                  ptr        <= nrow_base;
                  last       <= nrow_base + 32'(COLS - 1);
                  Memwrite   <= 2'b01;
                  Addrin     <= nrow_base;
                  BUS        <= {24'd0, BLANK};
               end
            end
            LCLR, SCLR: begin
               // No strobe yet only when the sweep was entered straight from reset
               if (!Memwrite[0]) begin
                  busy     <= 1'b1;
                  Memwrite <= 2'b01;
                  Addrin   <= ptr;
                  BUS      <= {24'd0, BLANK};
               end else if (ptr == last) begin
                  st         <= IDLE;
                  char_ready <= 1'b1;
                  busy       <= 1'b0;
                  if (st == SCLR) begin
                     cursor_row <= 5'd0;
                     cursor_col <= 5'd0;
                  end
               end else begin
                  ptr      <= ptr + 32'd1;
                  Memwrite <= 2'b01;
                  Addrin   <= ptr + 32'd1;
                  BUS      <= {24'd0, BLANK};
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
